// File: rtl/line_fill_ctrl_if.sv
// Cache-miss / memory-word / line-fill signal bundle for line_fill_ctrl.
// master = fill controller, slave = cache + memory side.
interface line_fill_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
);
  logic                    miss_valid;
  logic [ADDR_W-1:0]       miss_addr;
  logic                    miss_ready;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ack;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    fill_valid;
  logic [ADDR_W-1:0]       fill_base;
  logic [DATA_W*WORDS-1:0] fill_line;
  logic                    fill_err;

  modport master (
    input  miss_valid, miss_addr, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_valid, fill_base, fill_line, fill_err
  );

  modport slave (
    output miss_valid, miss_addr, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_valid, fill_base, fill_line, fill_err
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// Line fill requester: fetches WORDS words critical-word-first with wrap inside the line,
// assembles them by line offset and presents the finished line with a one-cycle pulse.
module line_fill_ctrl #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  line_fill_ctrl_if.master bus
);
  localparam int OFS_W = $clog2(WORDS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int HI_W  = ADDR_W - OFS_W;

  typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

  state_t                       state, nxt;
  logic [HI_W-1:0]              base_hi;
  logic [OFS_W-1:0]             ofs;
  logic [OFS_W-1:0]             cnt;
  logic [TO_W-1:0]              tcnt;
  logic [WORDS-1:0][DATA_W-1:0] lbuf, slot_d, line_q;
  logic [ADDR_W-1:0]            base_q;
  logic                         acc, ack_ok, last;

  assign acc    = bus.miss_valid & (state == IDLE);
  assign ack_ok = bus.mem_ack & (state == FETCH);
  assign last   = ack_ok & (cnt == OFS_W'(WORDS - 1));

  // Arriving word is merged by offset so the final ack can publish the full line directly.
  always_comb begin
    slot_d = lbuf;
    for (int i = 0; i < WORDS; i++)
      if (ack_ok && ofs == OFS_W'(i)) slot_d[i] = bus.mem_rdata;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.miss_valid) nxt = FETCH;
      FETCH: begin
        if (ack_ok) begin
          if (last) nxt = DONE;
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          nxt = ERR;
        end
      end
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_hi <= '0;
      ofs     <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      lbuf    <= '0;
    end else if (acc) begin
      base_hi <= bus.miss_addr[ADDR_W-1:OFS_W];
      ofs     <= bus.miss_addr[OFS_W-1:0];
      cnt     <= '0;
      tcnt    <= '0;
    end else if (ack_ok) begin
      lbuf <= slot_d;
      ofs  <= ofs + 1'b1;  // wraps inside the line, base never carries
      cnt  <= cnt + 1'b1;
      tcnt <= '0;
    end else if (state == FETCH) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Published line only changes on a completed fill; an aborted fill leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      base_q <= '0;
    end else if (last) begin
      line_q <= slot_d;
      base_q <= {base_hi, {OFS_W{1'b0}}};
    end
  end

  assign bus.miss_ready = (state == IDLE);
  assign bus.mem_req    = (state == FETCH);
  assign bus.mem_addr   = {base_hi, ofs};
  assign bus.fill_valid = (state == DONE);
  assign bus.fill_err   = (state == ERR);
  assign bus.fill_base  = base_q;
  assign bus.fill_line  = line_q;
endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: behavioural memory responder plus hand-computed
// fetch order, slot placement, latency, timeout and reset expectations.
module tb_line_fill_ctrl;
  localparam int ADDR_W = 28, DATA_W = 32, WORDS = 4, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus();

  line_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_run = 0, n_fail = 0;
  int cyc = 0, delay = 0, stall_at = -1, nacks = 0, wcnt = 0;
  int fv_cnt = 0, fe_cnt = 0, fv_cyc = 0, fe_cyc = 0, stall_n = 0, unst = 0, acc_cyc = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ADDR_W-1:0] alog[$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input logic [ADDR_W-1:0] a);
    return {4'hD, a} ^ 32'h0055_AA00;
  endfunction

  function automatic logic [127:0] exp_line(input logic [ADDR_W-1:0] base);
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < WORDS; i++) l[i*DATA_W +: DATA_W] = mdat(base | ADDR_W'(i));
    return l;
  endfunction

  function automatic logic [111:0] order4();
    return {alog[0], alog[1], alog[2], alog[3]};
  endfunction

  // One clock: memory responder and pulse monitors evaluated at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.mem_req && prev_req && !prev_ack && bus.mem_addr !== prev_addr) unst++;
    bus.mem_ack = 1'b0;
    if (bus.mem_req && rst_n) begin
      if (nacks == stall_at) stall_n++;
      else if (wcnt == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mdat(bus.mem_addr);
        alog.push_back(bus.mem_addr);
        wcnt = 0;
        nacks++;
      end else wcnt++;
    end
    prev_req  = bus.mem_req;
    prev_addr = bus.mem_addr;
    prev_ack  = bus.mem_ack;
    if (bus.fill_valid) begin fv_cnt++; fv_cyc = cyc; end
    if (bus.fill_err)   begin fe_cnt++; fe_cyc = cyc; end
  endtask

  task automatic setup(input int d, input int st);
    delay = d; stall_at = st; nacks = 0; wcnt = 0; stall_n = 0; unst = 0;
    fv_cnt = 0; fe_cnt = 0;
    alog.delete();
  endtask

  // Called at a falling edge with miss_ready high: acceptance happens on the next rising edge.
  task automatic miss(input logic [ADDR_W-1:0] a);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = a;
    acc_cyc = cyc;
    step();
    bus.miss_valid = 1'b0;
  endtask

  task automatic run_fill(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (fv_cnt != 0 || fe_cnt != 0) break;
      step();
    end
    chk({tag, "_ended"}, 1'((fv_cnt != 0) || (fe_cnt != 0)), 1'b1);
  endtask

  initial begin
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    // reset state
    step(); step();
    chk("rst_ready", bus.miss_ready, 1'b1);
    chk("rst_req",   bus.mem_req,    1'b0);
    chk("rst_addr",  bus.mem_addr,   '0);
    chk("rst_fv",    bus.fill_valid, 1'b0);
    chk("rst_fe",    bus.fill_err,   1'b0);
    chk("rst_base",  bus.fill_base,  '0);
    chk("rst_line",  bus.fill_line,  '0);
    rst_n = 1'b1;
    step();

    // 1: aligned miss, ack every cycle; DONE is the 6th cycle counting the accept cycle
    setup(0, -1);
    miss(28'h0000010);
    run_fill("t1", 20);
    chk("t1_lat",   32'(fv_cyc - acc_cyc), 32'd5);
    chk("t1_order", order4(), {28'h10, 28'h11, 28'h12, 28'h13});
    chk("t1_base",  bus.fill_base, 28'h10);
    chk("t1_line",  bus.fill_line, exp_line(28'h10));
    step();
    chk("t1_fv_pulse", bus.fill_valid, 1'b0);
    chk("t1_ready",    bus.miss_ready, 1'b1);
    chk("t1_fv_cnt",   32'(fv_cnt), 32'd1);

    // 2: critical word at offset 2 wraps, slots by address
    setup(0, -1);
    miss(28'h0000016);
    run_fill("t2", 20);
    chk("t2_order", order4(), {28'h16, 28'h17, 28'h14, 28'h15});
    chk("t2_base",  bus.fill_base, 28'h14);
    chk("t2_line",  bus.fill_line, exp_line(28'h14));
    step();

    // 3: ack three cycles late per word -> 4 cycles/word, DONE 17 cycles after accept
    setup(3, -1);
    miss(28'h0000023);
    run_fill("t3", 40);
    chk("t3_lat",    32'(fv_cyc - acc_cyc), 32'd17);
    chk("t3_stable", 32'(unst), 32'd0);
    chk("t3_noerr",  32'(fe_cnt), 32'd0);
    chk("t3_order",  order4(), {28'h23, 28'h20, 28'h21, 28'h22});
    chk("t3_line",   bus.fill_line, exp_line(28'h20));
    step();

    // 4: no ack on the third word -> abort after TIMEOUT unanswered request cycles
    setup(0, 2);
    miss(28'h0000031);
    run_fill("t4", 200);
    chk("t4_fe_cnt",   32'(fe_cnt), 32'd1);
    chk("t4_fv_none",  32'(fv_cnt), 32'd0);
    chk("t4_waited",   32'(stall_n), 32'(TIMEOUT));
    chk("t4_lat",      32'(fe_cyc - acc_cyc), 32'(TIMEOUT + 3));
    chk("t4_req_err",  bus.mem_req, 1'b0);
    step();
    chk("t4_fe_pulse", bus.fill_err, 1'b0);
    chk("t4_ready",    bus.miss_ready, 1'b1);
    chk("t4_req_low",  bus.mem_req, 1'b0);
    chk("t4_line_kept", bus.fill_line, exp_line(28'h20));
    chk("t4_base_kept", bus.fill_base, 28'h20);

    // 5: asynchronous reset after two acks, then a fresh fill
    setup(0, -1);
    miss(28'h0000042);
    step();
    chk("t5_two_acks", 32'(alog.size()), 32'd2);
    #2 rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_req_async",   bus.mem_req,    1'b0);
    chk("t5_ready_async", bus.miss_ready, 1'b1);
    chk("t5_fv_async",    bus.fill_valid, 1'b0);
    chk("t5_line_async",  bus.fill_line,  '0);
    step(); step();
    rst_n = 1'b1;
    step();
    setup(0, -1);
    miss(28'h0000043);
    run_fill("t5", 20);
    chk("t5_order", order4(), {28'h43, 28'h40, 28'h41, 28'h42});
    chk("t5_line",  bus.fill_line, exp_line(28'h40));
    chk("t5_lat",   32'(fv_cyc - acc_cyc), 32'd5);
    step();

    // 6: miss_valid held through FETCH and DONE; second miss taken in the first IDLE cycle
    setup(0, -1);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 28'h0000050;
    acc_cyc = cyc;
    step();
    bus.miss_addr = 28'h0000064;
    begin
      int busy = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.miss_ready) break;
        busy++;
        step();
      end
      chk("t6_busy_cycles", 32'(busy), 32'd5);
    end
    chk("t6_fv_seen",  32'(fv_cnt), 32'd1);
    chk("t6_acc2_cyc", 32'(cyc - fv_cyc), 32'd1);
    chk("t6_base1",    bus.fill_base, 28'h50);
    alog.delete();
    fv_cnt = 0;
    acc_cyc = cyc;
    step();
    bus.miss_valid = 1'b0;
    chk("t6_ready_low", bus.miss_ready, 1'b0);
    run_fill("t6", 20);
    chk("t6_order", order4(), {28'h64, 28'h65, 28'h66, 28'h67});
    chk("t6_line",  bus.fill_line, exp_line(28'h64));
    step(); step(); step();
    chk("t6_no_third", 32'(alog.size()), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
